// File: rtl/madd_error_monitor.sv
// Exhaustive error monitor for an approximate a*b+c circuit.
// Ports:
//   clk, rst            clock and async active-high reset
//   start               request to begin a sweep (taken in IDLE only)
//   busy                high from accepted start until result accepted
//   stim                DUT inputs: a=[W-1:0], b=[2W-1:W], c=[3W-1:2W]
//   dut_out             DUT result, sampled DUT_LAT cycles after stim
//   res_valid/ready     result handshake
//   max_err, err_sum,
//   err_cnt, pass       error statistics and verdict (max_err <= ET)
//   fail_vec, fail_valid
//                       first vector with error > ET; present only
//                       when MADD_MON_FIRST_FAIL_EN is defined
module madd_error_monitor #(
  parameter int OP_W    = 2,
  parameter int ET      = 6,
  parameter int DUT_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [3*OP_W-1:0] stim,
  input  logic [2*OP_W-1:0] dut_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2*OP_W-1:0] max_err,
  output logic [5*OP_W-1:0] err_sum,
  output logic [3*OP_W:0]   err_cnt,
  output logic              pass
`ifdef MADD_MON_FIRST_FAIL_EN
  ,
  output logic [3*OP_W-1:0] fail_vec,
  output logic              fail_valid
`endif
);

  localparam int VW = 3*OP_W;
  localparam int RW = 2*OP_W;
  localparam int SW = 5*OP_W;
  localparam int CW = 3*OP_W+1;
  localparam int DW = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [VW-1:0] cnt;
  logic [DW-1:0] dcnt;

  // Tag pipeline tracks which vector dut_out belongs to.
  logic [VW-1:0]      tag_vec [DUT_LAT];
  logic [DUT_LAT-1:0] tag_vld;

  logic          go;
  logic          push;
  logic          smp;
  logic          to_done;
  logic [VW-1:0] smp_vec;
  logic [OP_W-1:0] sa;
  logic [OP_W-1:0] sb;
  logic [OP_W-1:0] sc;
  logic [RW-1:0] exact;
  logic [RW-1:0] err;
  logic [RW-1:0] max_nxt;

  assign go      = (state == IDLE) && start;
  assign push    = (state == SWEEP);
  assign smp     = tag_vld[DUT_LAT-1];
  assign smp_vec = tag_vec[DUT_LAT-1];
  assign to_done = (state == DRAIN) && (state_nxt == DONE);

  assign sa = smp_vec[OP_W-1:0];
  assign sb = smp_vec[2*OP_W-1:OP_W];
  assign sc = smp_vec[VW-1:2*OP_W];

  // Cannot overflow RW bits: max is 2^RW - 2^OP_W.
  assign exact = RW'(sa) * RW'(sb) + RW'(sc);
  assign err   = (dut_out >= exact) ? dut_out - exact
                                    : exact - dut_out;

  // Includes the sample landing on the DRAIN->DONE edge.
  assign max_nxt = (smp && (err > max_err)) ? err : max_err;

  assign busy      = (state != IDLE);
  assign res_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (start) state_nxt = SWEEP;
      SWEEP: if (cnt == '1) state_nxt = DRAIN;
      DRAIN: if (dcnt == DW'(DUT_LAT-1)) state_nxt = DONE;
      DONE:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      dcnt    <= '0;
      stim    <= '0;
      tag_vld <= '0;
      for (int i = 0; i < DUT_LAT; i++) begin
        tag_vec[i] <= '0;
      end
      max_err <= '0;
      err_sum <= '0;
      err_cnt <= '0;
      pass    <= 1'b0;
    end else begin
      for (int i = DUT_LAT-1; i >= 1; i--) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_vec[i] <= tag_vec[i-1];
      end
      tag_vld[0] <= push;
      tag_vec[0] <= cnt;

      if (push) begin
        stim <= cnt;
        cnt  <= cnt + 1'b1;
      end

      if (state == DRAIN) begin
        dcnt <= dcnt + 1'b1;
      end else begin
        dcnt <= '0;
      end

      if (go) begin
        cnt     <= '0;
        max_err <= '0;
        err_sum <= '0;
        err_cnt <= '0;
        pass    <= 1'b0;
      end else if (smp) begin
        max_err <= max_nxt;
        err_sum <= err_sum + SW'(err);
        err_cnt <= err_cnt + CW'(err != '0);
      end

      if (to_done) begin
        pass <= (32'(max_nxt) <= 32'(ET));
      end
    end
  end

`ifdef MADD_MON_FIRST_FAIL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else if (go) begin
      fail_vec   <= '0;
      fail_valid <= 1'b0;
    end else if (smp && !fail_valid &&
                 (32'(err) > 32'(ET))) begin
      fail_vec   <= smp_vec;
      fail_valid <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_madd_error_monitor.sv
// Bench for madd_error_monitor: two monitor instances
// (DUT_LAT=1 with combinational DUT, DUT_LAT=3 with pipelined DUT).
module tb_madd_error_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start3;
  logic       res_ready;
  logic       res_ready3;

  logic       busy, busy3;
  logic [5:0] stim, stim3;
  logic [3:0] dut_out, dut_out3;
  logic       res_valid, res_valid3;
  logic [3:0] max_err, max_err3;
  logic [9:0] err_sum, err_sum3;
  logic [6:0] err_cnt, err_cnt3;
  logic       pass, pass3;
`ifdef MADD_MON_FIRST_FAIL_EN
  logic [5:0] fail_vec, fail_vec3;
  logic       fail_valid, fail_valid3;
`endif

  int mode1 = 0;
  int mode3 = 0;

  int n_vec = 0;
  int n_err = 0;

  int e1_mx, e1_sm, e1_ct, e1_ps, e1_fv, e1_fl;
  int e3_mx, e3_sm, e3_ct, e3_ps, e3_fv, e3_fl;

  logic [3:0] p1, p2;

  always #5 clk = ~clk;

  // Circuit-under-test behaviours:
  // 0 exact, 1 stuck at 0, 2 constant 15, 3 exact + 1
  function automatic int dut_val(input int mode, input int ex);
    case (mode)
      1:       return 0;
      2:       return 15;
      3:       return ex + 1;
      default: return ex;
    endcase
  endfunction

  function automatic int exact_of(input int v);
    return (v % 4) * ((v / 4) % 4) + (v / 16);
  endfunction

  assign dut_out = 4'(dut_val(mode1, exact_of(int'(stim))));

  // Compute stage plus two registers: value valid 3 cycles
  // after stim changes.
  always @(posedge clk) begin
    p1 <= 4'(dut_val(mode3, exact_of(int'(stim3))));
    p2 <= p1;
  end
  assign dut_out3 = p2;

  madd_error_monitor u_mon (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .stim      (stim),
    .dut_out   (dut_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .max_err   (max_err),
    .err_sum   (err_sum),
    .err_cnt   (err_cnt),
    .pass      (pass)
`ifdef MADD_MON_FIRST_FAIL_EN
    ,
    .fail_vec  (fail_vec),
    .fail_valid(fail_valid)
`endif
  );

  madd_error_monitor #(.DUT_LAT(3)) u_mon3 (
    .clk       (clk),
    .rst       (rst),
    .start     (start3),
    .busy      (busy3),
    .stim      (stim3),
    .dut_out   (dut_out3),
    .res_valid (res_valid3),
    .res_ready (res_ready3),
    .max_err   (max_err3),
    .err_sum   (err_sum3),
    .err_cnt   (err_cnt3),
    .pass      (pass3)
`ifdef MADD_MON_FIRST_FAIL_EN
    ,
    .fail_vec  (fail_vec3),
    .fail_valid(fail_valid3)
`endif
  );

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Whole-sweep statistics straight from the definitions.
  task automatic model(input int mode, output int mx,
                       output int sm, output int ct,
                       output int ps, output int fv,
                       output int fl);
    mx = 0; sm = 0; ct = 0; fv = 0; fl = 0;
    for (int v = 0; v < 64; v++) begin
      int ex, o, e;
      ex = exact_of(v);
      o  = dut_val(mode, ex);
      e  = (o > ex) ? o - ex : ex - o;
      if (e > mx) mx = e;
      sm += e;
      if (e != 0) ct++;
      if (e > 6 && fl == 0) begin
        fv = v;
        fl = 1;
      end
    end
    ps = (mx <= 6) ? 1 : 0;
  endtask

  // Result port checked every cycle it is presented.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      chk("max_err", int'(max_err), e1_mx);
      chk("err_sum", int'(err_sum), e1_sm);
      chk("err_cnt", int'(err_cnt), e1_ct);
      chk("pass", int'(pass), e1_ps);
      chk("busy_in_done", int'(busy), 1);
`ifdef MADD_MON_FIRST_FAIL_EN
      chk("fail_vec", int'(fail_vec), e1_fv);
      chk("fail_valid", int'(fail_valid), e1_fl);
`endif
    end
    if (!rst && res_valid3) begin
      chk("max_err3", int'(max_err3), e3_mx);
      chk("err_sum3", int'(err_sum3), e3_sm);
      chk("err_cnt3", int'(err_cnt3), e3_ct);
      chk("pass3", int'(pass3), e3_ps);
`ifdef MADD_MON_FIRST_FAIL_EN
      chk("fail_vec3", int'(fail_vec3), e3_fv);
      chk("fail_valid3", int'(fail_valid3), e3_fl);
`endif
    end
  end

  task automatic kick1(input int mode);
    mode1 = mode;
    model(mode, e1_mx, e1_sm, e1_ct, e1_ps, e1_fv, e1_fl);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run1(input int mode, input int lat);
    int n;
    kick1(mode);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1 n++;
      if (res_valid) break;
    end
    chk("latency1", n, lat);
    @(negedge clk);
  endtask

  task automatic run3(input int mode, input int lat);
    int n;
    mode3 = mode;
    model(mode, e3_mx, e3_sm, e3_ct, e3_ps, e3_fv, e3_fl);
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1 n++;
      if (res_valid3) break;
    end
    chk("latency3", n, lat);
    @(negedge clk);
  endtask

  task automatic accept1();
    @(negedge clk);
    res_ready = 1'b1;
    @(posedge clk);
    #1 res_ready = 1'b0;
    chk("acc_valid", int'(res_valid), 0);
    chk("acc_busy", int'(busy), 0);
  endtask

  task automatic accept3();
    @(negedge clk);
    res_ready3 = 1'b1;
    @(posedge clk);
    #1 res_ready3 = 1'b0;
    chk("acc_valid3", int'(res_valid3), 0);
    chk("acc_busy3", int'(busy3), 0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    start3     = 1'b0;
    res_ready  = 1'b0;
    res_ready3 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stim", int'(stim), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_max", int'(max_err), 0);
    chk("rst_sum", int'(err_sum), 0);
    chk("rst_cnt", int'(err_cnt), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_valid3", int'(res_valid3), 0);
`ifdef MADD_MON_FIRST_FAIL_EN
    chk("rst_fvld", int'(fail_valid), 0);
    chk("rst_fvec", int'(fail_vec), 0);
`endif
    rst = 1'b0;

    // Exact DUT
    run1(0, 65);
    chk("ex_max", int'(max_err), 0);
    chk("ex_sum", int'(err_sum), 0);
    chk("ex_cnt", int'(err_cnt), 0);
    chk("ex_pass", int'(pass), 1);
    accept1();

    // Stuck at zero
    run1(1, 65);
    chk("s0_max", int'(max_err), 12);
    chk("s0_sum", int'(err_sum), 240);
    chk("s0_cnt", int'(err_cnt), 57);
    chk("s0_pass", int'(pass), 0);
`ifdef MADD_MON_FIRST_FAIL_EN
    chk("s0_fvec", int'(fail_vec), 'h0F);
    chk("s0_fvld", int'(fail_valid), 1);
`endif
    accept1();
    chk("s0_hold", int'(max_err), 12);

    // Constant 15, result held with stray start
    run1(2, 65);
    chk("cf_max", int'(max_err), 15);
    chk("cf_sum", int'(err_sum), 720);
    chk("cf_cnt", int'(err_cnt), 64);
    chk("cf_pass", int'(pass), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      start = (i == 4);
      chk("hold_valid", int'(res_valid), 1);
      chk("hold_sum", int'(err_sum), 720);
    end
    @(negedge clk);
    start     = 1'b1;
    res_ready = 1'b1;
    @(posedge clk);
    #1 start  = 1'b0;
    res_ready = 1'b0;
    chk("cf_acc_valid", int'(res_valid), 0);
    chk("cf_acc_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    chk("cf_idle_busy", int'(busy), 0);
    chk("cf_idle_max", int'(max_err), 15);

    // Abort at vector 30 then rerun
    kick1(1);
    repeat (31) @(posedge clk);
    #1 chk("ab_stim", int'(stim), 30);
    rst = 1'b1;
    @(negedge clk);
    chk("ab_valid", int'(res_valid), 0);
    chk("ab_busy", int'(busy), 0);
    chk("ab_cnt", int'(err_cnt), 0);
    chk("ab_sum", int'(err_sum), 0);
    chk("ab_stim0", int'(stim), 0);
    rst = 1'b0;
    run1(1, 65);
    chk("rr_max", int'(max_err), 12);
    chk("rr_sum", int'(err_sum), 240);
    chk("rr_cnt", int'(err_cnt), 57);
    accept1();

    // Pipelined DUT, latency 3
    run3(0, 67);
    chk("l3_max", int'(max_err3), 0);
    chk("l3_cnt", int'(err_cnt3), 0);
    chk("l3_pass", int'(pass3), 1);
    accept3();
    run3(3, 67);
    chk("ob_max", int'(max_err3), 1);
    chk("ob_sum", int'(err_sum3), 64);
    chk("ob_cnt", int'(err_cnt3), 64);
    chk("ob_pass", int'(pass3), 1);
    accept3();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
